reg_ro_bank_shifter: RTL

//  Parametrised read-only register bank readout. NREG parallel words of WIDTH bits arrive on dataIn.

---
 rtl/reg_ro_bank_shifter.sv | 119 +++++++++++
 1 files changed

// File: rtl/reg_ro_bank_shifter.sv
// reg_ro_bank_shifter
//   Serial readout of a bank of read-only registers. latchOut captures the
//   word chosen by regSel, and each shiftEn cycle then presents one bit of it
//   on shiftOut. The bit order is selectable, and an even-parity bit can
//   optionally follow the data bits.
// Ports
//   bclk     : clock, all state on posedge
//   rst      : synchronous reset, active high, works even when clkEn=0
//   clkEn    : state advances only when 1
//   dataIn   : NREG words packed, reg k = dataIn[k*WIDTH +: WIDTH]
//   regSel   : register index used on a latch cycle
//   latchOut : load the selected word and start a new readout
//   shiftEn  : advance one bit
//   shiftOut : serial data (combinational)
//   busy     : state is SHIFT or PAR
//   done     : state is DONE
//   selErr   : last latch used an out-of-range regSel
module reg_ro_bank_shifter #(
  parameter int WIDTH     = 32,
  parameter int NREG      = 4,
  parameter int SELW      = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY    = 1'b0
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic                  clkEn,
  input  logic [NREG*WIDTH-1:0] dataIn,
  input  logic [SELW-1:0]       regSel,
  input  logic                  latchOut,
  input  logic                  shiftEn,
  output logic                  shiftOut,
  output logic                  busy,
  output logic                  done,
  output logic                  selErr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

  state_t           state, nextState;
  logic [WIDTH-1:0] shifter;
  logic [CW-1:0]    count;
  logic             parity;
  logic [WIDTH-1:0] selWord;
  logic             selValid;
  logic             advance;
  logic             outBit;

  // A latch always wins over a shift in the same cycle.
  assign advance = shiftEn & ~latchOut;

  // The bit at the output end of the shifter.
  assign outBit = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];

  // Register select. An out-of-range index loads an all-zero word.
  always_comb begin
    selWord  = '0;
    selValid = (int'(regSel) < NREG);
    for (int k = 0; k < NREG; k++)
      if (int'(regSel) == k) selWord = dataIn[k*WIDTH +: WIDTH];
  end

  // State register
  always_ff @(posedge bclk) begin
    if (rst)        state <= IDLE;
    else if (clkEn) state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    if (latchOut) begin
      nextState = SHIFT;
    end else begin
      case (state)
        SHIFT: if (shiftEn && count == CW'(1)) nextState = PARITY ? PAR : DONE;
        PAR:   if (shiftEn) nextState = DONE;
        default: nextState = state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    shiftOut = 1'b0;
    busy     = (state == SHIFT) || (state == PAR);
    done     = (state == DONE);
    case (state)
      SHIFT:   shiftOut = advance & outBit;
      PAR:     shiftOut = advance & parity;
      default: shiftOut = 1'b0;
    endcase
  end

  // Datapath: shifter, bit count, stored parity, select error
  always_ff @(posedge bclk) begin
    if (rst) begin
      shifter <= '0;
      count   <= '0;
      parity  <= 1'b0;
      selErr  <= 1'b0;
    end else if (clkEn) begin
      if (latchOut) begin
        shifter <= selWord;
        count   <= CW'(WIDTH);
        parity  <= ^selWord;
        selErr  <= ~selValid;
      end else if (state == SHIFT && shiftEn) begin
        // Move the next bit toward the output end and fill with zeros.
        shifter <= MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0}
                             : {1'b0, shifter[WIDTH-1:1]};
        count   <= count - CW'(1);
      end
    end
  end

endmodule
